// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-stream ingress path.
//   ingress_state_t : frame-policing FSM states
//   ERR_BIT         : tuser bit carrying the error flag
package axis_pkg;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    DROP = 1'b1
  } ingress_state_t;

  localparam int unsigned ERR_BIT = 0;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream register slice: an output register backed by one skid register.
// Both the forward path (out_*) and the backward path (in_ready) are registered.
// Ports:
//   clk, rst                              : clock, asynchronous active-high reset
//   in_data/in_last/in_user/in_valid      : upstream beat
//   in_ready                              : registered ready, high when the skid entry is free
//   out_data/out_last/out_user/out_valid  : downstream beat (output register)
//   out_ready                             : downstream ready
module axis_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [USER_WIDTH-1:0] in_user,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned PayloadWidth = DATA_WIDTH + 1 + USER_WIDTH;

  logic [PayloadWidth-1:0] in_pl;
  logic [PayloadWidth-1:0] out_pl_q, out_pl_d;
  logic [PayloadWidth-1:0] skid_pl_q, skid_pl_d;
  logic                    out_valid_q, out_valid_d;
  logic                    skid_valid_q, skid_valid_d;
  logic                    ready_q;
  logic                    in_fire;

  assign in_pl   = {in_data, in_last, in_user};
  assign in_fire = in_valid && ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pl_d     = out_pl_q;
    skid_valid_d = skid_valid_q;
    skid_pl_d    = skid_pl_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees up: the skid entry (older) has priority. While the skid is
      // full ready_q is low, so no new beat can arrive in the same cycle.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pl_d     = skid_pl_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_pl_d    = in_pl;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_pl_d    = in_pl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_pl_q     <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pl_q     <= out_pl_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  // Skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_pl_q <= skid_pl_d;
  end

  assign in_ready                       = ready_q;
  assign out_valid                      = out_valid_q;
  assign {out_data, out_last, out_user} = out_pl_q;

endmodule

// File: rtl/axis_ingress.sv
// AXI-stream ingress boundary with per-frame length policing.
// Beats pass through a registered skid buffer. Frames longer than MAX_FRAME_BEATS are cut
// at the limit: the last kept beat gets tlast=1 and tuser[ERR_BIT]=1, the rest is dropped.
// Ports:
//   clk, rst                              : clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tuser      : external stream in
//   s_tready                              : registered ready to the external source
//   m_tdata/m_tvalid/m_tlast/m_tuser      : registered stream to the parser
//   m_tready                              : parser ready
//   frame_cnt                             : frames accepted into the buffer (wraps)
//   trunc_cnt                             : truncated frames (saturates)
module axis_ingress
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned MAX_FRAME_BEATS = 1522
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic [31:0]           frame_cnt,
  output logic [15:0]           trunc_cnt
);

  localparam int unsigned CntWidth = $clog2(MAX_FRAME_BEATS + 1);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(MAX_FRAME_BEATS - 1);

  ingress_state_t        state_q;
  logic [CntWidth-1:0]   beat_cnt_q;
  logic                  buf_ready;
  logic                  buf_valid;
  logic                  buf_last;
  logic [USER_WIDTH-1:0] buf_user;
  logic                  accept;
  logic                  at_max;
  logic                  overflow;

  // Both terms are flops. In DROP the source is always drained; in PASS the skid's
  // registered ready reflects whether a beat can still be absorbed.
  assign s_tready = (state_q == DROP) || buf_ready;
  assign accept   = s_tvalid && s_tready;
  assign at_max   = (beat_cnt_q == LastIdx);
  assign overflow = at_max && !s_tlast;
  assign buf_valid = accept && (state_q == PASS);

  always_comb begin
    buf_last = s_tlast | overflow;
    buf_user = s_tuser;
    if (overflow) begin
      buf_user[ERR_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PASS;
      beat_cnt_q <= '0;
      frame_cnt  <= '0;
      trunc_cnt  <= '0;
    end else if (accept) begin
      unique case (state_q)
        PASS: begin
          if (s_tlast || at_max) begin
            beat_cnt_q <= '0;
            frame_cnt  <= frame_cnt + 32'd1;
            if (overflow) begin
              state_q <= DROP;
              if (trunc_cnt != 16'hFFFF) begin
                trunc_cnt <= trunc_cnt + 16'd1;
              end
            end
          end else begin
            beat_cnt_q <= beat_cnt_q + CntWidth'(1);
          end
        end
        DROP: begin
          if (s_tlast) begin
            beat_cnt_q <= '0;
            state_q    <= PASS;
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_tdata),
    .in_last  (buf_last),
    .in_user  (buf_user),
    .in_valid (buf_valid),
    .in_ready (buf_ready),
    .out_data (m_tdata),
    .out_last (m_tlast),
    .out_user (m_tuser),
    .out_valid(m_tvalid),
    .out_ready(m_tready)
  );

endmodule

// File: tb/tb_axis_ingress.sv
module tb_axis_ingress;

  localparam int DW   = 8;
  localparam int UW   = 1;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic [31:0]   frame_cnt;
  logic [15:0]   trunc_cnt;

  always #5 clk = ~clk;

  axis_ingress #(
    .DATA_WIDTH     (DW),
    .USER_WIDTH     (UW),
    .MAX_FRAME_BEATS(MAXB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .frame_cnt(frame_cnt),
    .trunc_cnt(trunc_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks    = 0;
  int    n_fail      = 0;
  int    exp_frames  = 0;
  int    exp_trunc   = 0;
  int    waits_total = 0;
  bit    chk_latency = 1'b0;
  bit    rand_ready_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected beat per output transfer; also checks that a
  // stalled output holds its value.
  beat_t mon_e;
  beat_t prev_pl;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_payload", 64'({m_tdata, m_tlast, m_tuser}), 64'(prev_pl));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h, expected none", {m_tdata, m_tlast, m_tuser});
        end else begin
          mon_e = exp_q.pop_front();
          check("out_beat", 64'({m_tdata, m_tlast, m_tuser}), 64'(mon_e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_pl    = {m_tdata, m_tlast, m_tuser};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [UW-1:0] u);
    int w;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      w++;
      if (w > 500) begin
        $display("FAIL send_timeout: got no s_tready, expected accept within 500 cycles");
        $fatal(1, "stuck");
      end
    end
    waits_total += w;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if (chk_latency) begin
      check("latency_valid", 64'(m_tvalid), 64'd1);
      check("latency_data", 64'(m_tdata), 64'(d));
    end
  endtask

  // Reference model at frame level: keep the first MAXB beats; an oversized frame ends on
  // beat MAXB with the error bit set.
  task automatic send_frame(input int len, input logic [DW-1:0] base, input bit rnd);
    beat_t b[$];
    beat_t e;
    for (int i = 0; i < len; i++) begin
      e.data = rnd ? DW'($urandom) : DW'(base + i);
      e.last = (i == len - 1);
      e.user = rnd ? UW'($urandom_range(0, 7) == 0) : '0;
      b.push_back(e);
    end
    for (int i = 0; i < len && i < MAXB; i++) begin
      e = b[i];
      if (len > MAXB && i == MAXB - 1) begin
        e.last    = 1'b1;
        e.user[0] = 1'b1;
      end
      exp_q.push_back(e);
    end
    exp_frames++;
    if (len > MAXB) exp_trunc++;
    for (int i = 0; i < len; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(b[i].data, b[i].last, b[i].user);
    end
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d beats outstanding, expected 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string name);
    check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    check({name, "_trunc_cnt"}, 64'(trunc_cnt), 64'(exp_trunc));
  endtask

  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_payload", 64'({m_tdata, m_tlast, m_tuser}), 64'd0);
    check_counters("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 64'(s_tready), 64'd1);

    // Single 4-beat frame, one-cycle latency per beat.
    m_tready    = 1'b1;
    chk_latency = 1'b1;
    send_frame(4, 8'h01, 1'b0);
    wait_drain("t1_drain");
    check_counters("t1");

    // Back-to-back frames at full rate: source never waits.
    waits_total = 0;
    send_frame(5, 8'h20, 1'b0);
    send_frame(3, 8'h30, 1'b0);
    send_frame(1, 8'h40, 1'b0);
    chk_latency = 1'b0;
    check("full_rate_waits", 64'(waits_total), 64'd0);
    wait_drain("t2_drain");
    check_counters("t2");

    // Back-pressure mid-frame: output + skid hold two beats, source is stalled.
    for (int i = 0; i < 6; i++) exp_q.push_back({DW'(8'h50 + i), (i == 5), UW'(0)});
    exp_frames++;
    send_beat(8'h50, 1'b0, '0);
    send_beat(8'h51, 1'b0, '0);
    m_tready = 1'b0;
    send_beat(8'h52, 1'b0, '0);
    repeat (5) begin
      @(negedge clk);
      check("bp_s_tready", 64'(s_tready), 64'd0);
      check("bp_head", 64'({m_tvalid, m_tdata}), 64'({1'b1, 8'h51}));
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_beat(8'h53, 1'b0, '0);
    send_beat(8'h54, 1'b0, '0);
    send_beat(8'h55, 1'b1, '0);
    wait_drain("t3_drain");
    check_counters("t3");

    // Oversized frame truncated, then a clean short frame.
    send_frame(11, 8'h10, 1'b0);
    send_frame(3, 8'h60, 1'b0);
    wait_drain("t4_drain");
    check_counters("t4");

    // Exactly maximum-length frame is legal.
    send_frame(MAXB, 8'h70, 1'b0);
    wait_drain("t5_drain");
    check_counters("t5");

    // Randomised frames with random gaps and random back-pressure.
    rand_ready_en = 1'b1;
    repeat (40) send_frame($urandom_range(1, 12), 8'h00, 1'b1);
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    m_tready = 1'b1;
    wait_drain("rand_drain");
    check_counters("rand");

    // Reset with two beats buffered mid-frame.
    m_tready = 1'b0;
    send_beat(8'h80, 1'b0, '0);
    send_beat(8'h81, 1'b0, '0);
    check("pre_rst_s_tready", 64'(s_tready), 64'd0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_frames = 0;
    exp_trunc  = 0;
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_payload", 64'({m_tdata, m_tlast, m_tuser}), 64'd0);
    check_counters("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_frame(2, 8'h90, 1'b0);
    wait_drain("t6_drain");
    check_counters("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_ingress.md
# axis_ingress

AXI-stream ingress boundary: the receive-side counterpart to the pass-through egress port. Every external beat is registered through a two-entry skid buffer, so timing is cut on both `tdata/tvalid` and `tready`. Each frame is length-policed against `MAX_FRAME_BEATS`. Oversized frames are truncated, marked with an error bit on the forced last beat, and the remainder is discarded. Sits between the external stream and the parser pipeline.

## Interface
- `DATA_WIDTH`, 8, tdata width in bits
- `USER_WIDTH`, 1, tuser width; must be ≥1, bit 0 is the error flag
- `MAX_FRAME_BEATS`, 1522, maximum beats per frame, ≥2
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `s_tdata`  in  DATA_WIDTH  external data
- `s_tvalid`  in  1  external valid
- `s_tready`  out  1  registered ready to external source
- `s_tlast`  in  1  external end of frame
- `s_tuser`  in  USER_WIDTH  external sideband
- `m_tdata`  out  DATA_WIDTH  internal data, registered
- `m_tvalid`  out  1  internal valid
- `m_tready`  in  1  internal ready
- `m_tlast`  out  1  internal end of frame
- `m_tuser`  out  USER_WIDTH  internal sideband; bit 0 ORed with the truncation error
- `frame_cnt`  out  32  frames accepted into the buffer; wraps
- `trunc_cnt`  out  16  truncated frames; saturates at 0xFFFF

## Operation
- Input beat accepted when `s_tvalid && s_tready`.
- Flow control: `m_*` is the output register, backed by one skid register.
- State `PASS` (reset state):
  - Accepted beat is written to the output register, or to the skid register if the output is occupied and not draining.
  - `beat_cnt` increments; width is `$clog2(MAX_FRAME_BEATS+1)`.
  - Beat with `s_tlast=1` while `beat_cnt < MAX_FRAME_BEATS-1`: forwarded unchanged; `beat_cnt` goes to 0; `frame_cnt` increments.
  - Beat with `beat_cnt == MAX_FRAME_BEATS-1` and `s_tlast=0`: forwarded with `tlast=1` and `tuser[0]=1`; `frame_cnt` and `trunc_cnt` increment; go to `DROP`.
  - Beat with `beat_cnt == MAX_FRAME_BEATS-1` and `s_tlast=1`: a legal maximum-length frame; forwarded unchanged, no error.
- State `DROP`:
  - Accepted beats are discarded; nothing enters the buffer.
  - Beat with `s_tlast=1`: `beat_cnt` goes to 0; return to `PASS`.
- `s_tready` next value = (next state is `DROP`) OR (skid register empty next cycle).
- Incoming `s_tuser[0]=1` passes through untouched. It is never cleared, and it is never counted as a truncation.

## Timing
- Latency is 1 cycle from input accept to `m_tvalid`, with the buffer empty.
- Throughput is 1 beat/cycle sustained when `m_tready=1`.
- `m_tvalid` never drops while `m_tready=0`. `m_tdata`, `m_tlast` and `m_tuser` are stable while `m_tvalid && !m_tready`.
- Back-pressure:
  - `m_tready` low while the output is occupied: the next accepted beat fills the skid register.
  - `s_tready` is 0 from the following cycle.
  - No beat is lost or duplicated.
- Simultaneous output drain and input accept with the skid register full: the skid moves to the output, and the new beat is not accepted because `s_tready` was 0.
- Reset values while `rst` is asserted:
  - `s_tready`=0, `m_tvalid`=0, `m_tdata`/`m_tlast`/`m_tuser`=0.
  - Counters 0, state `PASS`, `beat_cnt`=0.
  - `s_tready` rises on the first clock edge after deassertion.
- Reset mid-frame: buffered beats are lost. The next accepted beat after reset starts a new frame.

## Structure
- Package `axis_pkg`:
  - `ingress_state_t` enum {`PASS`, `DROP`}
  - `ERR_BIT = 0` constant
- Sub-module `axis_skid_buffer` (DATA+LAST+USER payload, registered ready, no reset of payload required). It is shared later by other pipeline stages.
- `axis_ingress` holds the policing FSM, the counters, and one `axis_skid_buffer` instance.

## Test plan
Tests use `MAX_FRAME_BEATS=8` unless stated.
- Reset release, `m_tready=1`, 4-beat frame 0x01..0x04 → emerges 1 cycle later, `tlast` on 0x04, `tuser`=0, `frame_cnt`=1.
- Back-to-back frames at full rate, `m_tready=1` → one beat out per cycle; `s_tready` stays 1.
- `m_tready` held 0 for 5 cycles mid-frame → exactly 2 beats buffered and `s_tready`=0. On release, the beats emerge in order with no gaps or duplicates.
- 11-beat frame 0x10..0x1A:
  - Output is 0x10..0x17, with `tlast`=1 and `tuser[0]`=1 on 0x17.
  - 0x18..0x1A are dropped; `trunc_cnt`=1.
  - The following 3-beat frame passes clean.
- Exactly 8-beat frame with `tlast` on beat 8 → no error, `trunc_cnt` unchanged.
- `rst` asserted while 2 beats are buffered mid-frame → all outputs 0 immediately. After release, a fresh 2-beat frame passes with `frame_cnt`=1.
